// File: rtl/bound_flasher_seq.sv
// bound_flasher_seq: main-state sequencer driving a thermometer lamp bar with kickback
module bound_flasher_seq #(
    parameter int N_LAMPS  = 16,
    parameter int MID_LO   = 5,
    parameter int MID_HI   = 10,
    parameter int STEP_DIV = 1,
    localparam int CW = $clog2(N_LAMPS + 1)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flick,
    output logic [2:0]         main_state,
    output logic [2:0]         main_state_n,
    output logic [N_LAMPS-1:0] lamp,
    output logic [CW-1:0]      cnt,
    output logic               busy
);
    localparam int PW = (STEP_DIV > 1) ? $clog2(STEP_DIV) : 1;
    localparam logic [PW-1:0] PRE_MAX = PW'(STEP_DIV - 1);
    localparam logic [CW-1:0] C_FULL = CW'(N_LAMPS);
    localparam logic [CW-1:0] C_LO   = CW'(MID_LO);
    localparam logic [CW-1:0] C_HI   = CW'(MID_HI);
    localparam logic [CW-1:0] K_LO   = CW'(MID_LO + 1);
    localparam logic [CW-1:0] K_HI   = CW'(MID_HI + 1);
    localparam logic [2:0] IDLE = 3'd0, UP15 = 3'd1, DN5 = 3'd2, UP10 = 3'd3,
                           DN0A = 3'd4, UP5 = 3'd5, DN0B = 3'd6, KB = 3'd7;

    logic [PW-1:0] pre, pre_n;
    logic [CW-1:0] cnt_n, target;
    logic [2:0]    succ;
    logic          tick, up;

    // State, fill count and prescaler registers; reset aborts without ramp-down
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            main_state <= IDLE;
            cnt        <= '0;
            pre        <= PRE_MAX;
        end else begin
            main_state <= main_state_n;
            cnt        <= cnt_n;
            pre        <= pre_n;
        end
    end

    // Next state and count: kickback first, then step toward the state's target
    always_comb begin
        tick   = (pre == PRE_MAX);
        up     = (main_state == UP15) || (main_state == UP10) || (main_state == UP5);
        target = (main_state == UP15) ? C_FULL :
                 (main_state == UP10) ? C_HI :
                 (main_state == DN5 || main_state == UP5) ? C_LO : '0;
        succ   = (main_state == KB) ? UP15 : (main_state == DN0B) ? IDLE : main_state + 3'd1;
        main_state_n = main_state;
        cnt_n        = cnt;
        pre_n        = pre + 1'b1;
        if (tick) begin
            if (main_state == IDLE) begin
                main_state_n = flick ? UP15 : IDLE;
            end else if (main_state == UP15 && flick && (cnt == K_LO || cnt == K_HI)) begin
                main_state_n = KB;
                cnt_n        = cnt - 1'b1;
            end else if (main_state == UP10 && flick && cnt == K_LO) begin
                main_state_n = DN5;
                cnt_n        = cnt - 1'b1;
            end else begin
                // A kickback into DN5 lands exactly on its target; just hand back to UP10
                cnt_n = (cnt == target) ? cnt : up ? cnt + 1'b1 : cnt - 1'b1;
                if (cnt_n == target) main_state_n = succ;
            end
            pre_n = (main_state_n == IDLE) ? PRE_MAX : '0;
        end
    end

    // Thermometer lamps and busy flag from registered state
    always_comb begin
        busy = (main_state != IDLE);
        for (int i = 0; i < N_LAMPS; i++) lamp[i] = (i < int'(cnt));
    end
endmodule

// File: tb/tb_bound_flasher_seq.sv
// tb_bound_flasher_seq: randomized check of two sequencer instances against a stage-table model
module tb_bound_flasher_seq;
    typedef struct {
        int stage;  // -1 idle, 0..5 ramp stages, 6 kickback ramp-down
        int cnt;
        int since;
    } mdl_t;

    localparam int DIV [2] = '{1, 4};
    localparam int TGT [6] = '{16, 5, 10, 0, 5, 0};

    logic        clk = 0, rst_n = 0;
    logic        fl [2];
    logic [2:0]  st [2], stn [2];
    logic [15:0] lp [2];
    logic [4:0]  cn [2];
    logic        by [2];
    mdl_t        m [2];
    int          tests = 0, fails = 0;

    always #5 clk = ~clk;

    bound_flasher_seq #(.STEP_DIV(1)) u0 (.clk(clk), .rst_n(rst_n), .flick(fl[0]),
        .main_state(st[0]), .main_state_n(stn[0]), .lamp(lp[0]), .cnt(cn[0]), .busy(by[0]));
    bound_flasher_seq #(.STEP_DIV(4)) u1 (.clk(clk), .rst_n(rst_n), .flick(fl[1]),
        .main_state(st[1]), .main_state_n(stn[1]), .lamp(lp[1]), .cnt(cn[1]), .busy(by[1]));

    task automatic chk(input string tag, input int got, input int exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0d expected=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    function automatic int code(mdl_t x);
        return (x.stage < 0) ? 0 : (x.stage == 6) ? 7 : x.stage + 1;
    endfunction

    function automatic bit kb_pt(mdl_t x);
        return (x.stage == 0 && (x.cnt == 6 || x.cnt == 11)) || (x.stage == 2 && x.cnt == 6);
    endfunction

    function automatic mdl_t step(mdl_t x, bit f, int dv);
        mdl_t r = x;
        if (x.stage >= 0 && x.since < dv - 1) begin
            r.since++;
            return r;
        end
        r.since = 0;
        if (x.stage < 0) begin
            if (f) r.stage = 0;
        end else if (x.stage == 6) begin
            r.cnt--;
            if (r.cnt == 0) r.stage = 0;
        end else if (f && kb_pt(x)) begin
            r.stage = (x.stage == 0) ? 6 : 1;
            r.cnt--;
        end else begin
            if (r.cnt != TGT[x.stage]) r.cnt += (TGT[x.stage] > r.cnt) ? 1 : -1;
            if (r.cnt == TGT[x.stage]) r.stage = (x.stage == 5) ? -1 : x.stage + 1;
        end
        return r;
    endfunction

    task automatic reset_models();
        for (int d = 0; d < 2; d++) m[d] = '{stage: -1, cnt: 0, since: 0};
    endtask

    // mode 0: flick low, 1: sparse random, 2: random plus bias toward kickback points
    task automatic cycle(input int mode);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("state%0d", d), st[d], code(m[d]));
            chk($sformatf("cnt%0d", d), cn[d], m[d].cnt);
            chk($sformatf("lamp%0d", d), lp[d], (1 << m[d].cnt) - 1);
            chk($sformatf("busy%0d", d), by[d], m[d].stage >= 0);
            fl[d] = (mode != 0) && (($urandom_range(0, 7) == 0) ||
                    (mode == 2 && kb_pt(m[d]) && $urandom_range(0, 1) == 1));
        end
        #1;
        for (int d = 0; d < 2; d++) begin
            m[d] = step(m[d], fl[d], DIV[d]);
            chk($sformatf("next%0d", d), stn[d], code(m[d]));
        end
    endtask

    initial begin
        bit found = 0;
        fl[0] = 0; fl[1] = 0;
        reset_models();
        repeat (3) @(negedge clk);
        rst_n = 1;
        repeat (20) cycle(0);
        for (int i = 0; i < 4000; i++) cycle(((i / 250) % 2 == 1) ? 2 : 1);
        for (int i = 0; i < 3000 && !found; i++) begin
            cycle(1);
            found = (code(m[0]) == 3 && m[0].cnt == 8);
        end
        chk("seek_mid_run", found, 1);
        @(posedge clk);
        #3 rst_n = 0;
        fl[0] = 0; fl[1] = 0;
        #1;
        for (int d = 0; d < 2; d++) begin
            chk($sformatf("arst_state%0d", d), st[d], 0);
            chk($sformatf("arst_cnt%0d", d), cn[d], 0);
            chk($sformatf("arst_lamp%0d", d), lp[d], 0);
            chk($sformatf("arst_busy%0d", d), by[d], 0);
        end
        reset_models();
        @(negedge clk);
        @(negedge clk);
        rst_n = 1;
        repeat (10) cycle(0);
        repeat (300) cycle(1);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
